// File: rtl/muldiv_sequencer_if.sv
// Request/result and ALU-side signals of the multiply/divide sequencer.
// slave: sequencer view. master: CPU control unit plus shared ALU view.
interface muldiv_sequencer_if;
  logic       start;
  logic       op_div;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       alu_op_mul;
  logic       alu_op_div;
  logic       alu_acc_lsb;
  logic [3:0] alu_acc_high;
  logic [3:0] alu_bus_b;
  logic [3:0] alu_data;
  logic       alu_cout;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] result;

  modport slave (
    input  start, op_div, a_in, b_in, alu_data, alu_cout,
    output alu_op_mul, alu_op_div, alu_acc_lsb, alu_acc_high, alu_bus_b,
    output busy, done, div_by_zero, result
  );

  modport master (
    output start, op_div, a_in, b_in, alu_data, alu_cout,
    input  alu_op_mul, alu_op_div, alu_acc_lsb, alu_acc_high, alu_bus_b,
    input  busy, done, div_by_zero, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Shift-add multiply / restoring divide controller driving a shared 4-bit ALU.
// Latency start->done: mul 5, div 9, div-by-zero 1 cycle; result updates when leaving DONE.
// No backpressure: start is sampled only in IDLE, anything else is dropped.
module muldiv_sequencer #(
  parameter int ITER = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST_IT = CW'(ITER - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL_IT  = 3'd1;
  localparam logic [2:0] S_DIV_SH  = 3'd2;
  localparam logic [2:0] S_DIV_SUB = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state;
  logic [7:0]    acc;
  logic [3:0]    b_reg;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          dbz;
  logic [7:0]    result_q;

  logic          mul_c;
  logic [3:0]    mul_h;
  logic          sub_ok;
  logic          last_it;

  // Per-iteration ALU interpretation: carry only counts when the add was taken;
  // a subtract also succeeds if the shifted-out bit made the partial remainder >15.
  always_comb begin
    mul_c   = bus.alu_cout & acc[0];
    mul_h   = acc[0] ? bus.alu_data : acc[7:4];
    sub_ok  = bus.alu_cout | ovf;
    last_it = (cnt == LAST_IT);
  end

  // Sequencer state, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      acc      <= 8'h00;
      b_reg    <= 4'h0;
      cnt      <= '0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
      result_q <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc   <= {4'h0, bus.a_in};
            b_reg <= bus.b_in;
            cnt   <= '0;
            dbz   <= 1'b0;
            if (!bus.op_div) begin
              state <= S_MUL_IT;
            end else if (bus.b_in == 4'h0) begin
              dbz   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_DIV_SH;
            end
          end
        end
        S_MUL_IT: begin
          acc <= {mul_c, mul_h, acc[3:1]};
          cnt <= cnt + CW'(1);
          if (last_it) state <= S_DONE;
        end
        S_DIV_SH: begin
          ovf   <= acc[7];
          acc   <= {acc[6:0], 1'b0};
          state <= S_DIV_SUB;
        end
        S_DIV_SUB: begin
          if (sub_ok) acc <= {bus.alu_data, acc[3:1], 1'b1};
          else        acc <= {acc[7:1], 1'b0};
          cnt   <= cnt + CW'(1);
          state <= last_it ? S_DONE : S_DIV_SH;
        end
        S_DONE: begin
          // On divide-by-zero acc still holds the untouched dividend.
          result_q <= dbz ? {acc[3:0], 4'hF} : acc;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_op_mul   = (state == S_MUL_IT);
  assign bus.alu_op_div   = (state == S_DIV_SUB);
  assign bus.alu_acc_lsb  = acc[0];
  assign bus.alu_acc_high = acc[7:4];
  assign bus.alu_bus_b    = b_reg;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_DONE);
  assign bus.div_by_zero  = dbz;
  assign bus.result       = result_q;

endmodule
